// File: rtl/game_pkg.sv
// Shared types and helpers for the board-game turn sequencer.
// The state enum and the roll clamp are kept here so every block agrees on them.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_START,
        ST_WAIT_DONE,
        ST_CHECK,
        ST_OVER
    } seq_state_t;

    localparam int TILE_W        = 4;
    localparam int DEF_LAST_TILE = 9;

    // Steps actually taken: the roll, limited by the step cap and by the distance left to the goal.
    function automatic logic [2:0] clamp_steps(input logic [2:0]        roll,
                                               input logic [TILE_W-1:0] tile,
                                               input logic [TILE_W-1:0] last,
                                               input logic [2:0]        max_steps);
        logic [TILE_W-1:0] remain;
        logic [2:0]        lim;
        remain = (tile >= last) ? '0 : last - tile;
        lim    = (roll > max_steps) ? max_steps : roll;
        return (remain < {1'b0, lim}) ? remain[2:0] : lim;
    endfunction

endpackage

// File: rtl/turn_rr_counter.sv
// Round-robin active-player register.
// A clear request takes priority over an advance request.
module turn_rr_counter #(
    parameter int NUM_PLAYERS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_advance,
    input  logic       i_clear,
    output logic [1:0] o_player
);
    localparam logic [1:0] LAST_P = 2'(NUM_PLAYERS - 1);

    logic [1:0] r_player;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_player <= '0;
        else if (i_clear)
            r_player <= '0;
        else if (i_advance)
            r_player <= (r_player == LAST_P) ? 2'd0 : r_player + 2'd1;
    end

    assign o_player = r_player;

endmodule

// File: rtl/turn_sequencer.sv
// Turn scheduler: turns each accepted dice roll into single-tile move triggers for the active player,
// waits for every move/jump to finish, and latches the winner when the goal tile is reached.
//
// state        | meaning
// IDLE         | waiting for a roll; roll_ready high
// ISSUE        | move_trigger pulse is on the wire; timeout timer loaded
// WAIT_START   | waiting for the active controller to raise is_moving
// WAIT_DONE    | move and jump in progress; waiting for is_moving to fall
// CHECK        | one cycle to read the updated tile and decide what follows
// OVER         | game finished; only restart is honoured
module turn_sequencer
    import game_pkg::*;
#(
    parameter int NUM_PLAYERS   = 2,
    parameter int LAST_TILE     = DEF_LAST_TILE,
    parameter int MAX_STEPS     = 6,
    parameter int START_TIMEOUT = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          roll_valid,
    input  logic [2:0]                    roll_steps,
    output logic                          roll_ready,
    input  logic                          restart,
    input  logic [NUM_PLAYERS-1:0]        is_moving,
    input  logic [TILE_W*NUM_PLAYERS-1:0] tiles_in,
    output logic [NUM_PLAYERS-1:0]        move_trigger,
    output logic [1:0]                    active_player,
    output logic [2:0]                    steps_left,
    output logic                          busy,
    output logic                          game_over,
    output logic [1:0]                    winner_id,
    output logic                          timeout_err
);
    localparam logic [TILE_W-1:0] LAST_T   = TILE_W'(LAST_TILE);
    localparam logic [2:0]        MAX_S    = 3'(MAX_STEPS);
    localparam int                TW       = $clog2(START_TIMEOUT + 1);
    localparam logic [TW-1:0]     TMR_LOAD = TW'(START_TIMEOUT - 1);

    seq_state_t r_state, w_state_nxt;

    logic [NUM_PLAYERS-1:0] r_trig, w_trig_nxt;
    logic [2:0]             r_steps, w_steps_nxt;
    logic                   r_busy, w_busy_nxt;
    logic                   r_over, w_over_nxt;
    logic [1:0]             r_winner, w_winner_nxt;
    logic                   r_terr, w_terr_nxt;
    logic                   r_ready, w_ready_nxt;
    logic [TW-1:0]          r_tmr;

    logic [TILE_W-1:0] w_tile;
    logic              w_moving;
    logic [2:0]        w_steps_eff;
    logic              w_accept;
    logic              w_timeout;
    logic              w_advance;
    logic              w_clear;
    logic [1:0]        w_active;

    turn_rr_counter #(.NUM_PLAYERS(NUM_PLAYERS)) u_rr (
        .clk       (clk),
        .rst       (rst),
        .i_advance (w_advance),
        .i_clear   (w_clear),
        .o_player  (w_active)
    );

    always_comb begin
        w_tile   = '0;
        w_moving = 1'b0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (w_active == 2'(p)) begin
                w_tile   = tiles_in[TILE_W*p +: TILE_W];
                w_moving = is_moving[p];
            end
        end
    end

    assign w_steps_eff = clamp_steps(roll_steps, w_tile, LAST_T, MAX_S);
    assign w_accept    = (r_state == ST_IDLE) && roll_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE:       if (w_accept && w_steps_eff != 3'd0) w_state_nxt = ST_ISSUE;
            ST_ISSUE:      w_state_nxt = ST_WAIT_START;
            ST_WAIT_START: begin
                if (w_moving)
                    w_state_nxt = ST_WAIT_DONE;
                else if (r_tmr == '0) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_DONE:  if (!w_moving) w_state_nxt = ST_CHECK;
            ST_CHECK: begin
                if (w_tile == LAST_T)
                    w_state_nxt = ST_OVER;
                else if (r_steps > 3'd1)
                    w_state_nxt = ST_ISSUE;
                else
                    w_state_nxt = ST_IDLE;
            end
            ST_OVER:       if (restart) w_state_nxt = ST_IDLE;
            default:       w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_trig_nxt   = '0;
        w_steps_nxt  = r_steps;
        w_busy_nxt   = r_busy;
        w_over_nxt   = r_over;
        w_winner_nxt = r_winner;
        w_terr_nxt   = r_terr;
        w_advance    = 1'b0;
        w_clear      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_steps_eff == 3'd0)
                        w_advance = 1'b1;
                    else begin
                        w_steps_nxt = w_steps_eff;
                        w_busy_nxt  = 1'b1;
                    end
                end
            end
            ST_WAIT_START: begin
                if (w_timeout) begin
                    w_terr_nxt  = 1'b1;
                    w_steps_nxt = '0;
                    w_busy_nxt  = 1'b0;
                    w_advance   = 1'b1;
                end
            end
            ST_CHECK: begin
                w_steps_nxt = r_steps - 3'd1;
                if (w_tile == LAST_T) begin
                    w_over_nxt   = 1'b1;
                    w_winner_nxt = w_active;
                    w_busy_nxt   = 1'b0;
                end else if (r_steps <= 3'd1) begin
                    w_busy_nxt = 1'b0;
                    w_advance  = 1'b1;
                end
            end
            ST_OVER: begin
                if (restart) begin
                    w_over_nxt = 1'b0;
                    w_clear    = 1'b1;
                end
            end
            default: ;
        endcase
        // The trigger is registered, so it is raised on the edge that enters ISSUE.
        if (w_state_nxt == ST_ISSUE) begin
            for (int p = 0; p < NUM_PLAYERS; p++)
                w_trig_nxt[p] = (w_active == 2'(p));
        end
        w_ready_nxt = (w_state_nxt == ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_trig   <= '0;
            r_steps  <= '0;
            r_busy   <= 1'b0;
            r_over   <= 1'b0;
            r_winner <= '0;
            r_terr   <= 1'b0;
            r_ready  <= 1'b1;
            r_tmr    <= '0;
        end else begin
            r_trig   <= w_trig_nxt;
            r_steps  <= w_steps_nxt;
            r_busy   <= w_busy_nxt;
            r_over   <= w_over_nxt;
            r_winner <= w_winner_nxt;
            r_terr   <= w_terr_nxt;
            r_ready  <= w_ready_nxt;
            if (r_state == ST_ISSUE)
                r_tmr <= TMR_LOAD;
            else if (r_state == ST_WAIT_START && r_tmr != '0)
                r_tmr <= r_tmr - TW'(1);
        end
    end

    assign move_trigger  = r_trig;
    assign active_player = w_active;
    assign steps_left    = r_steps;
    assign busy          = r_busy;
    assign game_over     = r_over;
    assign winner_id     = r_winner;
    assign timeout_err   = r_terr;
    assign roll_ready    = r_ready;

endmodule

// File: tb/tb_turn_sequencer.sv
// Bench for turn_sequencer: a small player_controller model answers triggers, expected triggers
// are queued by the stimulus and popped by an independent monitor; status is checked after each roll.
module tb_turn_sequencer;
    localparam int NP = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          roll_valid = 1'b0;
    logic [2:0]    roll_steps = '0;
    logic          restart = 1'b0;
    logic          roll_ready;
    logic [NP-1:0] is_moving;
    logic [4*NP-1:0] tiles_in;
    logic [NP-1:0] move_trigger;
    logic [1:0]    active_player;
    logic [2:0]    steps_left;
    logic          busy, game_over, timeout_err;
    logic [1:0]    winner_id;

    int n_vec = 0;
    int n_err = 0;

    logic [NP-1:0] exp_q[$];

    logic [3:0]    m_tile[NP] = '{4'd0, 4'd0};
    logic [NP-1:0] m_mov = '0;
    int            m_cnt[NP] = '{0, 0};
    logic          stall = 1'b0;
    logic          load_req = 1'b0;
    logic [3:0]    load_val[NP] = '{4'd0, 4'd0};

    assign is_moving = m_mov;
    assign tiles_in  = {m_tile[1], m_tile[0]};

    turn_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .roll_valid    (roll_valid),
        .roll_steps    (roll_steps),
        .roll_ready    (roll_ready),
        .restart       (restart),
        .is_moving     (is_moving),
        .tiles_in      (tiles_in),
        .move_trigger  (move_trigger),
        .active_player (active_player),
        .steps_left    (steps_left),
        .busy          (busy),
        .game_over     (game_over),
        .winner_id     (winner_id),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    // Controller model: busy for 4 cycles after a trigger, then one tile further on.
    always @(posedge clk) begin
        for (int p = 0; p < NP; p++) begin
            if (load_req) begin
                m_tile[p] <= load_val[p];
                m_mov[p]  <= 1'b0;
                m_cnt[p]  <= 0;
            end else if (m_mov[p]) begin
                if (m_cnt[p] == 0) begin
                    m_mov[p]  <= 1'b0;
                    m_tile[p] <= m_tile[p] + 4'd1;
                end else
                    m_cnt[p] <= m_cnt[p] - 1;
            end else if (move_trigger[p] && !stall) begin
                m_mov[p] <= 1'b1;
                m_cnt[p] <= 3;
            end
        end
    end

    always @(negedge clk) begin
        logic [NP-1:0] e;
        if (!rst && move_trigger != '0) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL trig_unexpected: got %b required none", move_trigger);
            end else begin
                e = exp_q.pop_front();
                if (move_trigger !== e) begin
                    n_err++;
                    $display("FAIL trig_vector: got %b required %b", move_trigger, e);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic set_tiles(input logic [3:0] t0, input logic [3:0] t1);
        @(negedge clk);
        load_val[0] = t0;
        load_val[1] = t1;
        load_req    = 1'b1;
        @(negedge clk);
        load_req    = 1'b0;
    endtask

    task automatic push_trig(input logic [NP-1:0] v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endtask

    task automatic do_roll(input logic [2:0] s);
        int i;
        i = 0;
        @(negedge clk);
        while (!roll_ready && i < 200) begin
            @(negedge clk);
            i++;
        end
        if (!roll_ready) begin
            n_err++;
            $display("FAIL roll_ready_wait: got 0 required 1");
        end
        roll_valid = 1'b1;
        roll_steps = s;
        @(posedge clk);
        #1 roll_valid = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (!(roll_ready || game_over) && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        if (!(roll_ready || game_over)) begin
            n_err++;
            $display("FAIL idle_wait: got busy required idle within 1000 cycles");
        end
    endtask

    initial begin
        int cyc;
        repeat (3) @(negedge clk);
        check("rst_roll_ready", roll_ready, 1);
        check("rst_trigger", move_trigger, 0);
        check("rst_active", active_player, 0);
        check("rst_steps", steps_left, 0);
        check("rst_busy", busy, 0);
        check("rst_over", game_over, 0);
        check("rst_winner", winner_id, 0);
        check("rst_timeout", timeout_err, 0);
        rst = 1'b0;

        set_tiles(4'd0, 4'd0);
        push_trig(2'b01, 3);
        do_roll(3'd3);
        check("roll3_busy_after_accept", busy, 1);
        check("roll3_steps_loaded", steps_left, 3);
        wait_idle(cyc);
        check("roll3_tile0", m_tile[0], 3);
        check("roll3_active", active_player, 1);
        check("roll3_busy", busy, 0);
        check("roll3_steps", steps_left, 0);
        check("roll3_queue", exp_q.size(), 0);

        push_trig(2'b10, 6);
        do_roll(3'd7);
        check("roll7_steps_clamped", steps_left, 6);
        wait_idle(cyc);
        check("roll7_tile1", m_tile[1], 6);
        check("roll7_active", active_player, 0);
        check("roll7_queue", exp_q.size(), 0);

        do_roll(3'd0);
        check("roll0_active", active_player, 1);
        check("roll0_ready", roll_ready, 1);
        check("roll0_busy", busy, 0);

        stall = 1'b1;
        push_trig(2'b10, 1);
        do_roll(3'd2);
        wait_idle(cyc);
        check("timeout_latency", cyc, 17);
        check("timeout_err", timeout_err, 1);
        check("timeout_busy", busy, 0);
        check("timeout_steps", steps_left, 0);
        check("timeout_active", active_player, 0);
        check("timeout_tile1", m_tile[1], 6);
        stall = 1'b0;

        set_tiles(4'd3, 4'd7);
        do_roll(3'd0);
        check("pre_win_active", active_player, 1);
        push_trig(2'b10, 2);
        do_roll(3'd6);
        check("win_steps_clamped", steps_left, 2);
        wait_idle(cyc);
        repeat (2) @(negedge clk);
        check("win_over", game_over, 1);
        check("win_winner", winner_id, 1);
        check("win_busy", busy, 0);
        check("win_ready", roll_ready, 0);
        check("win_tile1", m_tile[1], 9);
        roll_valid = 1'b1;
        roll_steps = 3'd3;
        repeat (5) @(negedge clk);
        roll_valid = 1'b0;
        check("over_ignores_roll_busy", busy, 0);
        check("over_ignores_roll_ready", roll_ready, 0);
        check("over_queue", exp_q.size(), 0);

        restart = 1'b1;
        @(posedge clk);
        #1 restart = 1'b0;
        check("restart_active", active_player, 0);
        check("restart_ready", roll_ready, 1);
        check("restart_over", game_over, 0);
        check("restart_keeps_timeout", timeout_err, 1);

        set_tiles(4'd0, 4'd0);
        push_trig(2'b01, 1);
        do_roll(3'd3);
        cyc = 0;
        while (!is_moving[0] && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("mid_move_started", is_moving[0], 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_state", {roll_ready, move_trigger, active_player, steps_left, busy,
                               game_over, winner_id, timeout_err}, 13'b1_00_00_000_0_0_00_0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("midrst_no_more_triggers", exp_q.size(), 0);
        check("midrst_idle_busy", busy, 0);

        do_roll(3'd0);
        check("idle_roll0_active", active_player, 1);
        @(negedge clk);
        restart = 1'b1;
        @(posedge clk);
        #1 restart = 1'b0;
        check("restart_ignored_idle", active_player, 1);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
